// File: rtl/operand_fetch_pkg.sv
// Shared source-select codes and FSM state encoding for the operand fetch stage.
package operand_fetch_pkg;

  localparam logic [2:0] SRC_A    = 3'b000;
  localparam logic [2:0] SRC_B    = 3'b001;
  localparam logic [2:0] SRC_ZERO = 3'b010;
  localparam logic [2:0] SRC_K    = 3'b011;
  localparam logic [2:0] SRC_MEM  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_OUT
  } state_e;

endpackage

// File: rtl/operand_src_mux.sv
// Per-operand source select. MEM and reserved codes yield zero; the memory
// value is filled in later by the fetch FSM.
module operand_src_mux
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel_i,
  input  logic [WIDTH-1:0] reg_a_i,
  input  logic [WIDTH-1:0] reg_b_i,
  input  logic [WIDTH-1:0] k_const_i,
  output logic [WIDTH-1:0] operand_o
);

  always_comb begin
    operand_o = '0;
    case (sel_i)
      SRC_A:           operand_o = reg_a_i;
      SRC_B:           operand_o = reg_b_i;
      SRC_K:           operand_o = k_const_i;
      SRC_ZERO,
      SRC_MEM:         operand_o = '0;
      default:         operand_o = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Registered operand fetch: builds two ALU operands, serialising up to two
// memory reads over one req/ack port with a per-read bounded wait.
module operand_fetch_unit
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        sel_a,
  input  logic [2:0]        sel_b,
  input  logic [WIDTH-1:0]  reg_a,
  input  logic [WIDTH-1:0]  reg_b,
  input  logic [WIDTH-1:0]  k_const,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [2:0]          sel_b_q, sel_b_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [WIDTH-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  logic [1:0][2:0]       sel_v;
  logic [1:0][WIDTH-1:0] src_v;

  assign sel_v = {sel_b, sel_a};

  for (genvar g = 0; g < 2; g++) begin : g_mux
    operand_src_mux #(.WIDTH(WIDTH)) u_mux (
      .sel_i     (sel_v[g]),
      .reg_a_i   (reg_a),
      .reg_b_i   (reg_b),
      .k_const_i (k_const),
      .operand_o (src_v[g])
    );
  end

  // A late ack in the final wait cycle still wins over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    sel_b_d  = sel_b_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    err_d    = err_q;
    cnt_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sel_b_d  = sel_b;
          addr_a_d = addr_a;
          addr_b_d = addr_b;
          op_a_d   = src_v[0];
          op_b_d   = src_v[1];
          err_d    = 1'b0;
          if (sel_a == SRC_MEM)      state_d = ST_FETCH_A;
          else if (sel_b == SRC_MEM) state_d = ST_FETCH_B;
          else                       state_d = ST_OUT;
        end
      end
      ST_FETCH_A: begin
        if (mem_ack || timeout_hit) begin
          op_a_d  = mem_ack ? mem_rdata : '0;
          err_d   = err_q | ~mem_ack;
          state_d = (sel_b_q == SRC_MEM) ? ST_FETCH_B : ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FETCH_B: begin
        if (mem_ack || timeout_hit) begin
          op_b_d  = mem_ack ? mem_rdata : '0;
          err_d   = err_q | ~mem_ack;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_b_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_b_q  <= sel_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake and memory-port outputs decode straight from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign mem_req   = (state_q == ST_FETCH_A) || (state_q == ST_FETCH_B);
  assign mem_addr  = (state_q == ST_FETCH_A) ? addr_a_q :
                     (state_q == ST_FETCH_B) ? addr_b_q : '0;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign err       = err_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: expectations queued at accept,
// popped and compared when out_valid appears.
module tb_operand_fetch_unit;

  localparam int W   = 8;
  localparam int AW  = 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [2:0]    sel_a = '0, sel_b = '0;
  logic [W-1:0]  reg_a = '0, reg_b = '0, k_const = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic          mem_req, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [W-1:0]  op_a, op_b;
  logic          err;

  operand_fetch_unit #(.WIDTH(W), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sel_a(sel_a), .sel_b(sel_b),
    .reg_a(reg_a), .reg_b(reg_b), .k_const(k_const),
    .addr_a(addr_a), .addr_b(addr_b),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err;
    int           lat;
    int           reqs;
  } exp_t;

  exp_t sb_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // d = wait cycles before ack within a read; negative = never acked.
  function automatic bit read_ok(input int d);
    return (d >= 0) && (d < TMO);
  endfunction

  function automatic logic [W-1:0] model_src(input logic [2:0] s, input logic [W-1:0] ra,
      input logic [W-1:0] rb, input logic [W-1:0] k, input logic [W-1:0] m, input int d);
    case (s)
      3'd0: return ra;
      3'd1: return rb;
      3'd3: return k;
      3'd4: return read_ok(d) ? m : '0;
      default: return '0;
    endcase
  endfunction

  task automatic txn(input logic [2:0] sa, input logic [2:0] sb,
      input logic [W-1:0] ra, input logic [W-1:0] rb, input logic [W-1:0] k,
      input logic [AW-1:0] aa, input logic [AW-1:0] ab,
      input logic [W-1:0] ma, input logic [W-1:0] mb,
      input int da, input int db, input int hold);
    exp_t e, g;
    logic [AW-1:0] ad[2];
    logic [W-1:0]  md[2];
    int dd[2];
    int nrd = 0, rd = 0, w = 0, reqs = 0;
    bit ack, done = 0;
    e.a   = model_src(sa, ra, rb, k, ma, da);
    e.b   = model_src(sb, ra, rb, k, mb, db);
    e.err = (sa == 3'd4 && !read_ok(da)) || (sb == 3'd4 && !read_ok(db));
    if (sa == 3'd4) begin ad[nrd] = aa; md[nrd] = ma; dd[nrd] = da; nrd++; end
    if (sb == 3'd4) begin ad[nrd] = ab; md[nrd] = mb; dd[nrd] = db; nrd++; end
    e.reqs = 0;
    for (int i = 0; i < nrd; i++) e.reqs += read_ok(dd[i]) ? dd[i] + 1 : TMO;
    e.lat = 1 + e.reqs;

    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; sel_a = sa; sel_b = sb; reg_a = ra; reg_b = rb; k_const = k;
    addr_a = aa; addr_b = ab;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    // Scramble inputs so a unit that re-samples after accept is caught.
    in_valid = 0; sel_a = 3'($urandom); sel_b = 3'($urandom);
    reg_a = W'($urandom); reg_b = W'($urandom); k_const = W'($urandom);
    addr_a = AW'($urandom); addr_b = AW'($urandom);

    for (int c = 1; c <= 64 && !done; c++) begin
      ack = 0; mem_ack = 0; mem_rdata = W'($urandom);
      if (out_valid) begin
        done = 1;
        if (sb_q.size() == 0) chk("sb_empty", 0, 1);
        else begin
          g = sb_q.pop_front();
          chk("latency", c, g.lat);
          chk("op_a", op_a, g.a);
          chk("op_b", op_b, g.b);
          chk("err", err, g.err);
          chk("req_cycles", reqs, g.reqs);
          out_ready = (hold == 0);
          for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_op_a", op_a, g.a);
            chk("bp_op_b", op_b, g.b);
            chk("bp_err", err, g.err);
            @(posedge clk); #1;
          end
          in_valid = 0; out_ready = 1;
          @(posedge clk); #1;
          out_ready = 0;
          chk("idle_after_out", in_ready, 1);
        end
      end else if (mem_req) begin
        reqs++;
        if (rd < nrd) begin
          chk("mem_addr", mem_addr, ad[rd]);
          ack = (w == dd[rd]);
          mem_ack = ack;
          if (ack) mem_rdata = md[rd];
        end else chk("extra_read", rd, nrd);
        @(posedge clk); #1;
        if (ack || w == TMO - 1) begin rd++; w = 0; end
        else w++;
      end else begin
        @(posedge clk); #1;
      end
    end
    mem_ack = 0;
    if (!done) chk("out_valid_wait", 0, 1);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // register + constant operands
    txn(3'd0, 3'd3, 8'h3C, 8'h99, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    // two reads, 2 wait cycles each
    txn(3'd4, 3'd4, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'hAA, 8'h55, 2, 2, 0);
    // timeout on A, then ack in the final wait cycle
    txn(3'd4, 3'd2, 8'h11, 8'h22, 8'h33, 8'h40, 8'h00, 8'hC3, 8'h00, -1, 0, 0);
    txn(3'd4, 3'd2, 8'h11, 8'h22, 8'h33, 8'h41, 8'h00, 8'h5A, 8'h00, 3, 0, 0);
    // backpressure, then back-to-back request
    txn(3'd1, 3'd0, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 5);
    txn(3'd3, 3'd4, 8'h00, 8'h00, 8'hE1, 8'h00, 8'h62, 8'h00, 8'h9D, 0, 0, 0);
    // reserved code
    txn(3'd7, 3'd2, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    // equal addresses, two distinct reads
    txn(3'd4, 3'd4, 8'h00, 8'h00, 8'h00, 8'h77, 8'h77, 8'h12, 8'h34, 0, 1, 0);
    // timeout on B only
    txn(3'd1, 3'd4, 8'h00, 8'h4B, 8'h00, 8'h00, 8'h90, 8'h00, 8'hEE, 0, -1, 0);

    // reset while fetching B after A has timed out (err already set)
    sel_a = 3'd4; sel_b = 3'd4; addr_a = 8'h33; addr_b = 8'h44; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (TMO + 1) @(posedge clk);
    #1;
    chk("pre_rst_req", mem_req, 1);
    chk("pre_rst_addr", mem_addr, 8'h44);
    chk("pre_rst_err", err, 1);
    #2 rst_n = 0;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_valid", out_valid, 0);
    chk("async_err", err, 0);
    chk("async_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 8'hFF;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("stray_req", mem_req, 0);
    chk("stray_valid", out_valid, 0);
    chk("stray_ready", in_ready, 1);
    chk("stray_op_a", op_a, 0);
    txn(3'd4, 3'd0, 8'h6D, 8'h00, 8'h00, 8'h05, 8'h00, 8'hB4, 8'h00, 1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      txn(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          W'($urandom), W'($urandom), W'($urandom), AW'($urandom), AW'($urandom),
          W'($urandom), W'($urandom),
          int'($urandom_range(0, 6)) - 1, int'($urandom_range(0, 6)) - 1,
          int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Registered operand-fetch stage for the 8-bit CPU datapath; the parametrised successor to the ALU operand-select mux. It accepts one instruction's operand selections through a valid/ready handshake. It builds both ALU operands from register A, register B, zero, a constant K, or memory, and serialises up to two memory reads over one shared request/acknowledge port with a bounded-wait timeout. It presents both operands as a held output record until the execute stage accepts them.

## Interface
- WIDTH, 8: data width of A, B, K, memory data and operands.
- ADDR_W, 8: memory address width.
- TIMEOUT, 15: maximum cycles waited for mem_ack per read; 0 disables the timeout.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high only in IDLE.
- sel_a, sel_b  in  3  source codes: 000 A, 001 B, 010 ZERO, 011 K, 100 MEM; 101–111 reserved, read as zero.
- reg_a, reg_b, k_const  in  WIDTH  source values, sampled at accept.
- addr_a, addr_b  in  ADDR_W  memory addresses for each operand, sampled at accept.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address, stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  WIDTH  read data.
- out_valid  out  1  operands ready.
- out_ready  in  1  consumer accepts.
- op_a, op_b  out  WIDTH  fetched operands.
- err  out  1  at least one read of this transaction timed out.

## Operation
- States: IDLE, FETCH_A, FETCH_B, OUT.
- **IDLE:** an accept occurs when in_valid and in_ready are both high. On accept:
  - Capture sel_a, sel_b, addr_a and addr_b.
  - Load every non-MEM operand from its source (reg_a, reg_b, 0 or k_const, sampled that edge).
  - Clear err.
  - Go to FETCH_A if sel_a is MEM, else to FETCH_B if sel_b is MEM, else to OUT.
- **FETCH_A / FETCH_B:**
  - mem_req is high and mem_addr is the captured address for that operand.
  - On mem_ack, latch mem_rdata into that operand. FETCH_A then goes to FETCH_B if sel_b is MEM, else to OUT. FETCH_B goes to OUT.
- **Timeout:**
  - A wait counter clears on entry to each FETCH state.
  - If TIMEOUT is nonzero and the counter reaches TIMEOUT-1 without mem_ack, that operand becomes 0, err sets, and the unit advances as if the read had been acknowledged.
  - mem_ack arriving in the timeout cycle wins: the data is latched and err stays clear.
- **OUT:** out_valid is high; op_a, op_b and err are held stable. When out_ready is high, go to IDLE.
- Both operands MEM with equal addresses: two separate reads, no merging.
- mem_ack in IDLE or OUT is ignored.
- Reserved select codes produce 0 and do not set err.

## Timing
- Reset values:
  - State IDLE, in_ready 1.
  - mem_req 0, mem_addr 0.
  - out_valid 0, op_a 0, op_b 0, err 0.
  - Wait counter 0.
- Asserting rst_n low mid-fetch drops mem_req immediately (asynchronous). Any in-flight mem_ack after release is ignored.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- **Latency from the accept edge (cycle 0):**
  - No MEM operand: out_valid in cycle 1.
  - One MEM operand: mem_req from cycle 1. With mem_ack in cycle 1 + d, out_valid is in cycle 2 + d.
  - Two MEM operands: the FETCH_B request starts the cycle after the FETCH_A acknowledge. mem_req stays continuously high across the two fetches, and mem_addr switches at that edge.
- Back-to-back throughput: at most one transaction per 2 cycles. The IDLE cycle after OUT is mandatory.
- Worst case per read: TIMEOUT cycles in FETCH.

## Structure
- Package operand_fetch_pkg:
  - Source-code constants SRC_A, SRC_B, SRC_ZERO, SRC_K, SRC_MEM.
  - State enum.
- Sub-module operand_src_mux: combinational, parametrised by WIDTH. It maps a 3-bit code to reg_a, reg_b, 0, k_const, or 0 for MEM and reserved codes. It is instantiated once per operand, and its output is loaded at accept.
- The FSM and wait counter live in the top level.

## Test plan
- **Register operands:** sel_a=000, sel_b=011, reg_a=8'h3C, k_const=8'h05 -> out_valid one cycle after accept, op_a=3C, op_b=05, err=0, mem_req never asserted.
- **Two reads:** both MEM, addr_a=10, addr_b=20; ack after 2 wait cycles each with data AA then 55 -> mem_addr 10 then 20, op_a=AA, op_b=55, out_valid 7 cycles after accept.
- **Timeout:** TIMEOUT=4, sel_a=MEM, no ack -> mem_req high exactly 4 cycles, op_a=00, err=1. A second run with ack in the 4th cycle gives data latched and err=0.
- **Output backpressure:** out_ready low for 5 cycles -> outputs stable, in_ready=0, and in_valid pulses are not accepted. Then a back-to-back request is accepted one cycle after the OUT handshake.
- **Reset mid-fetch:** rst_n low while mem_req is high -> mem_req, out_valid and err drop without waiting for a clock edge. A stray ack after release is ignored, and the next transaction completes normally.
- **Reserved code:** sel_a=111, sel_b=010 -> op_a=00, op_b=00, err=0.
